// File: rtl/power_arbiter.sv
// rtl/power_arbiter.sv - two-channel round-robin front end for a shared complex-power pipeline
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   chN_re/chN_im/chN_valid   channel N signed sample and valid (N = 0, 1)
//   chN_ready                 channel N grant, combinational
//   pow_re/pow_im/pow_valid   registered issue into the shared power pipeline
//   pow_dout/pow_dout_valid   result returned by the shared pipeline, in issue order
//   dout/dout_valid/dout_ch   routed result, one-cycle strobe, owning channel
//   tag_err                   sticky: a result arrived with no outstanding tag
//   occupancy                 number of issued samples whose result is still outstanding
module power_arbiter #(
    parameter int DIN_WIDTH = 16,
    parameter int TAG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DIN_WIDTH-1:0]  ch0_re,
    input  logic signed [DIN_WIDTH-1:0]  ch0_im,
    input  logic                         ch0_valid,
    output logic                         ch0_ready,
    input  logic signed [DIN_WIDTH-1:0]  ch1_re,
    input  logic signed [DIN_WIDTH-1:0]  ch1_im,
    input  logic                         ch1_valid,
    output logic                         ch1_ready,
    output logic signed [DIN_WIDTH-1:0]  pow_re,
    output logic signed [DIN_WIDTH-1:0]  pow_im,
    output logic                         pow_valid,
    input  logic [2*DIN_WIDTH:0]         pow_dout,
    input  logic                         pow_dout_valid,
    output logic [2*DIN_WIDTH:0]         dout,
    output logic                         dout_valid,
    output logic                         dout_ch,
    output logic                         tag_err,
    output logic [$clog2(TAG_DEPTH):0]   occupancy
);

    localparam int AW = $clog2(TAG_DEPTH);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(TAG_DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic          last_grant;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          tag_mem [TAG_DEPTH];

    logic xfer0;
    logic xfer1;
    logic push;
    logic pop;

    // Grant logic. Fullness is judged on the registered occupancy only, so a
    // pop in the same cycle never frees a slot early.
    always_comb begin
        ch0_ready = 1'b0;
        ch1_ready = 1'b0;
        if (!rst && occupancy != OCC_FULL) begin
            if (ch0_valid && ch1_valid) begin
                // last_grant holds the channel that transferred last; the other wins.
                ch0_ready = last_grant;
                ch1_ready = !last_grant;
            end else begin
                ch0_ready = ch0_valid;
                ch1_ready = ch1_valid;
            end
        end
    end

    assign xfer0 = ch0_valid && ch0_ready;
    assign xfer1 = ch1_valid && ch1_ready;
    assign push  = xfer0 || xfer1;
    assign pop   = pow_dout_valid && (occupancy != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            pow_valid  <= 1'b0;
            pow_re     <= '0;
            pow_im     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ch    <= 1'b0;
            tag_err    <= 1'b0;
        end else begin
            pow_valid <= push;
            if (push) begin
                pow_re     <= xfer1 ? ch1_re : ch0_re;
                pow_im     <= xfer1 ? ch1_im : ch0_im;
                last_grant <= xfer1;
                wr_ptr     <= wr_ptr + PTR_ONE;
            end

            dout_valid <= pop;
            if (pop) begin
                dout    <= pow_dout;
                dout_ch <= tag_mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end

            if (pow_dout_valid && occupancy == '0) begin
                tag_err <= 1'b1;
            end

            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Tag storage carries no reset: entries are only read behind rd_ptr,
    // and the pointers themselves are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= xfer1;
        end
    end

endmodule

// File: tb/tb_power_arbiter.sv
// tb/tb_power_arbiter.sv - randomized and directed bench for power_arbiter against a queue model
module tb_power_arbiter;

    localparam int W     = 16;
    localparam int DW    = 2*W+1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [W-1:0] ch0_re = '0, ch0_im = '0, ch1_re = '0, ch1_im = '0;
    logic ch0_valid = 1'b0, ch1_valid = 1'b0;
    logic ch0_ready, ch1_ready;
    logic signed [W-1:0] pow_re, pow_im;
    logic pow_valid;
    logic [DW-1:0] pow_dout;
    logic pow_dout_valid;
    logic [DW-1:0] dout;
    logic dout_valid, dout_ch, tag_err;
    logic [2:0] occupancy;

    // External pipeline: fixed 2-cycle squarer, or bench-driven returns.
    logic auto_pipe = 1'b0;
    logic man_v = 1'b0;
    logic [DW-1:0] man_d = '0;
    logic p0_v = 1'b0, p1_v = 1'b0;
    logic [DW-1:0] p0_d = '0, p1_d = '0;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    longint exp_pw[$];
    bit     exp_ch[$];
    bit     model_last = 1'b1;
    bit     model_err = 1'b0;
    bit     pend_v = 1'b0;
    longint pend_pw = 0;
    bit     pend_ch = 1'b0;
    bit     iss_v = 1'b0;
    logic signed [W-1:0] iss_re = '0, iss_im = '0;

    power_arbiter #(.DIN_WIDTH(W), .TAG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ch0_re(ch0_re), .ch0_im(ch0_im), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
        .ch1_re(ch1_re), .ch1_im(ch1_im), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
        .pow_re(pow_re), .pow_im(pow_im), .pow_valid(pow_valid),
        .pow_dout(pow_dout), .pow_dout_valid(pow_dout_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ch(dout_ch),
        .tag_err(tag_err), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic longint power_of(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
        longint r = re;
        longint i = im;
        return r*r + i*i;
    endfunction

    always @(posedge clk) begin
        p0_v <= pow_valid;
        p0_d <= DW'(power_of(pow_re, pow_im));
        p1_v <= p0_v;
        p1_d <= p0_d;
    end

    assign pow_dout_valid = auto_pipe ? p1_v : man_v;
    assign pow_dout       = auto_pipe ? p1_d : man_d;

    // One clock of stimulus with scoreboard tracking of every output.
    task automatic drive_cycle(input bit v0, input bit v1,
                               input logic signed [W-1:0] r0, input logic signed [W-1:0] i0,
                               input logic signed [W-1:0] r1, input logic signed [W-1:0] i1,
                               input bit pv, input longint pd,
                               output int obs_g, output bit obs_dv, output longint obs_d, output bit obs_ch);
        int g;
        @(negedge clk);
        ch0_valid = v0; ch0_re = r0; ch0_im = i0;
        ch1_valid = v1; ch1_re = r1; ch1_im = i1;
        man_v = pv; man_d = DW'(pd);
        #1;
        obs_g  = ch0_ready ? 0 : (ch1_ready ? 1 : -1);
        obs_dv = dout_valid;
        obs_d  = longint'(dout);
        obs_ch = dout_ch;

        tests_run++;
        if (dout_valid !== pend_v || (pend_v && (longint'(dout) != pend_pw || dout_ch !== pend_ch))) begin
            tests_failed++;
            $display("FAIL result: dv=%0b dout=%0d ch=%0b expected dv=%0b dout=%0d ch=%0b",
                     dout_valid, dout, dout_ch, pend_v, pend_pw, pend_ch);
        end
        tests_run++;
        if (pow_valid !== iss_v || (iss_v && (pow_re !== iss_re || pow_im !== iss_im))) begin
            tests_failed++;
            $display("FAIL issue: pv=%0b re=%0d im=%0d expected pv=%0b re=%0d im=%0d",
                     pow_valid, pow_re, pow_im, iss_v, iss_re, iss_im);
        end
        tests_run++;
        if (occupancy !== 3'(exp_ch.size())) begin
            tests_failed++;
            $display("FAIL occupancy: got %0d expected %0d", occupancy, exp_ch.size());
        end
        tests_run++;
        if (tag_err !== model_err) begin
            tests_failed++;
            $display("FAIL tag_err: got %0b expected %0b", tag_err, model_err);
        end

        g = -1;
        if (exp_ch.size() < DEPTH) begin
            if (v0 && v1) g = model_last ? 0 : 1;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        tests_run++;
        if (ch0_ready !== (g == 0) || ch1_ready !== (g == 1)) begin
            tests_failed++;
            $display("FAIL grant: ready0=%0b ready1=%0b expected grant %0d", ch0_ready, ch1_ready, g);
        end

        pend_v = 1'b0;
        if (pow_dout_valid === 1'b1) begin
            if (exp_ch.size() > 0) begin
                pend_v  = 1'b1;
                pend_pw = exp_pw.pop_front();
                pend_ch = exp_ch.pop_front();
            end else begin
                model_err = 1'b1;
            end
        end

        iss_v = 1'b0;
        if (g >= 0) begin
            iss_v  = 1'b1;
            iss_re = (g == 1) ? r1 : r0;
            iss_im = (g == 1) ? i1 : i0;
            exp_pw.push_back(power_of(iss_re, iss_im));
            exp_ch.push_back(g == 1);
            model_last = (g == 1);
        end
    endtask

    task automatic idle(input int n);
        int g; bit dv; longint d; bit c;
        for (int k = 0; k < n; k++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g, dv, d, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ch0_valid = 1'b1; ch1_valid = 1'b1; man_v = 1'b0;
        #1;
        tests_run++;
        if (pow_valid !== 1'b0 || pow_re !== '0 || pow_im !== '0 || dout !== '0 || dout_valid !== 1'b0 ||
            dout_ch !== 1'b0 || tag_err !== 1'b0 || occupancy !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: pv=%0b re=%0d im=%0d dout=%0d dv=%0b ch=%0b err=%0b occ=%0d expected all 0",
                     pow_valid, pow_re, pow_im, dout, dout_valid, dout_ch, tag_err, occupancy);
        end
        tests_run++;
        if (ch0_ready !== 1'b0 || ch1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: ready0=%0b ready1=%0b expected 0 0", ch0_ready, ch1_ready);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0; ch0_valid = 1'b0; ch1_valid = 1'b0;
        exp_pw.delete(); exp_ch.delete();
        model_last = 1'b1; model_err = 1'b0; pend_v = 1'b0; iss_v = 1'b0;
    endtask

    task automatic test_reset();
        auto_pipe = 1'b0;
        do_reset();
        idle(2);
    endtask

    task automatic test_contention();
        int g; bit dv; longint d; bit c;
        int grants[4];
        longint douts[$]; bit chs[$]; int first_dv;
        auto_pipe = 1'b1;
        do_reset();
        first_dv = -1;
        for (int k = 0; k < 12; k++) begin
            if (k < 4) drive_cycle(1, 1, 3, 4, 1, -2, 0, 0, g, dv, d, c);
            else       drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g, dv, d, c);
            if (k < 4) grants[k] = g;
            if (dv) begin
                if (first_dv < 0) first_dv = k;
                douts.push_back(d); chs.push_back(c);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (grants[k] !== k % 2) begin
                tests_failed++;
                $display("FAIL contention_grant[%0d]: got %0d expected %0d", k, grants[k], k % 2);
            end
        end
        tests_run++;
        if (douts.size() != 4) begin
            tests_failed++;
            $display("FAIL contention_count: got %0d results expected 4", douts.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (douts[k] != ((k % 2) ? 5 : 25) || chs[k] !== k[0]) begin
                    tests_failed++;
                    $display("FAIL contention_dout[%0d]: got %0d ch %0b expected %0d ch %0d",
                             k, douts[k], chs[k], (k % 2) ? 5 : 25, k % 2);
                end
            end
        end
        tests_run++;
        if (first_dv != 4) begin
            tests_failed++;
            $display("FAIL latency: first dout_valid at cycle %0d expected 4", first_dv);
        end
    endtask

    task automatic test_single();
        int g; bit dv; longint d; bit c; int n_res;
        auto_pipe = 1'b1;
        do_reset();
        n_res = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 10) drive_cycle(0, 1, 0, 0, W'($urandom), W'($urandom), 0, 0, g, dv, d, c);
            else        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g, dv, d, c);
            if (k < 10) begin
                tests_run++;
                if (g !== 1) begin
                    tests_failed++;
                    $display("FAIL single_ready[%0d]: grant %0d expected 1", k, g);
                end
            end
            if (dv) begin
                n_res++;
                tests_run++;
                if (c !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL single_ch: got %0b expected 1", c);
                end
            end
        end
        tests_run++;
        if (n_res != 10) begin
            tests_failed++;
            $display("FAIL single_count: got %0d expected 10", n_res);
        end
    endtask

    task automatic test_full();
        int g; bit dv; longint d; bit c; int n_x;
        auto_pipe = 1'b0;
        do_reset();
        n_x = 0;
        for (int k = 0; k < 7; k++) begin
            drive_cycle(1, 1, 3, 4, 1, -2, 0, 0, g, dv, d, c);
            if (g >= 0) n_x++;
        end
        tests_run++;
        if (n_x != 4 || g != -1 || occupancy !== 3'd4) begin
            tests_failed++;
            $display("FAIL full: transfers=%0d last_grant=%0d occ=%0d expected 4 -1 4", n_x, g, occupancy);
        end
        // Release one slot: the pop cycle itself must still block.
        drive_cycle(1, 1, 3, 4, 1, -2, 1, exp_pw[0], g, dv, d, c);
        tests_run++;
        if (g != -1) begin
            tests_failed++;
            $display("FAIL release_pop_cycle: grant %0d expected -1", g);
        end
        drive_cycle(1, 1, 3, 4, 1, -2, 0, 0, g, dv, d, c);
        tests_run++;
        if (g != 0 || !dv || d != 25 || c !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_next: grant %0d dv %0b dout %0d ch %0b expected 0 1 25 0", g, dv, d, c);
        end
        for (int k = 0; k < 8 && exp_pw.size() > 0; k++)
            drive_cycle(0, 0, 0, 0, 0, 0, 1, exp_pw[0], g, dv, d, c);
        idle(2);
    endtask

    task automatic test_underflow();
        int g; bit dv; longint d; bit c;
        auto_pipe = 1'b0;
        do_reset();
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 7, g, dv, d, c);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g, dv, d, c);
            tests_run++;
            if (dv || tag_err !== 1'b1) begin
                tests_failed++;
                $display("FAIL underflow[%0d]: dv=%0b tag_err=%0b expected 0 1", k, dv, tag_err);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int g; bit dv; longint d; bit c;
        auto_pipe = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) drive_cycle(1, 1, 3, 4, 1, -2, 0, 0, g, dv, d, c);
        do_reset();
        // Stale result from a pre-reset issue arrives with both channels contending.
        drive_cycle(1, 1, 5, 0, 0, 6, 1, 25, g, dv, d, c);
        tests_run++;
        if (g != 0) begin
            tests_failed++;
            $display("FAIL reset_first_grant: grant %0d expected 0", g);
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 1, exp_pw[0], g, dv, d, c);
        tests_run++;
        if (tag_err !== 1'b1 || dv) begin
            tests_failed++;
            $display("FAIL stale_result: tag_err=%0b dv=%0b expected 1 0", tag_err, dv);
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g, dv, d, c);
        tests_run++;
        if (!dv || d != 25 || c !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_result: dv=%0b dout=%0d ch=%0b expected 1 25 0", dv, d, c);
        end
    endtask

    task automatic test_push_pop();
        int g; bit dv; longint d; bit c;
        auto_pipe = 1'b0;
        do_reset();
        drive_cycle(1, 0, 3, 4, 0, 0, 0, 0, g, dv, d, c);
        drive_cycle(0, 1, 0, 0, 1, -2, 1, exp_pw[0], g, dv, d, c);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, exp_pw[0], g, dv, d, c);
        tests_run++;
        if (occupancy !== 3'd1 || !dv || c !== 1'b0 || d != 25) begin
            tests_failed++;
            $display("FAIL push_pop_first: occ=%0d dv=%0b ch=%0b dout=%0d expected 1 1 0 25", occupancy, dv, c, d);
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g, dv, d, c);
        tests_run++;
        if (!dv || c !== 1'b1 || d != 5 || occupancy !== 3'd0) begin
            tests_failed++;
            $display("FAIL push_pop_second: dv=%0b ch=%0b dout=%0d occ=%0d expected 1 1 5 0", dv, c, d, occupancy);
        end
    endtask

    task automatic test_max_magnitude();
        int g; bit dv; longint d; bit c; bit seen;
        auto_pipe = 1'b1;
        do_reset();
        seen = 1'b0;
        drive_cycle(1, 0, -32768, -32768, 0, 0, 0, 0, g, dv, d, c);
        for (int k = 0; k < 6; k++) begin
            drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g, dv, d, c);
            if (dv) begin
                seen = 1'b1;
                tests_run++;
                if (d != 64'd2147483648) begin
                    tests_failed++;
                    $display("FAIL max_magnitude: got %0d expected 2147483648", d);
                end
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL max_magnitude_timeout: no result seen");
        end
    endtask

    task automatic test_random();
        int g; bit dv; longint d; bit c; bit pv; bit stall;
        longint pipe_q[$];
        auto_pipe = 1'b0;
        do_reset();
        stall = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0) stall = !stall;
            pv = (pipe_q.size() > 0) && !stall && ($urandom_range(0, 2) != 0);
            drive_cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                        W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                        pv, pv ? pipe_q[0] : 0, g, dv, d, c);
            if (pv) void'(pipe_q.pop_front());
            if (pow_valid === 1'b1) pipe_q.push_back(power_of(pow_re, pow_im));
        end
        for (int k = 0; k < 20 && (pipe_q.size() > 0 || exp_ch.size() > 0 || pend_v); k++) begin
            pv = pipe_q.size() > 0;
            drive_cycle(0, 0, 0, 0, 0, 0, pv, pv ? pipe_q[0] : 0, g, dv, d, c);
            if (pv) void'(pipe_q.pop_front());
            if (pow_valid === 1'b1) pipe_q.push_back(power_of(pow_re, pow_im));
        end
        tests_run++;
        if (exp_ch.size() != 0 || pend_v) begin
            tests_failed++;
            $display("FAIL random_drain: %0d tags still outstanding in model", exp_ch.size());
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_full();
        test_underflow();
        test_reset_midstream();
        test_push_pop();
        test_max_magnitude();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/power_arbiter.md
POWER_ARBITER -- requirements
Module: power_arbiter

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16: signed sample width of each real and imaginary component.
REQ-002 SHALL have parameter TAG_DEPTH, default 8: tag FIFO depth; power of 2, at least 2; at least the shared power pipeline latency plus 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; every register SHALL be clocked on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports ch0_re, ch0_im, inputs, DIN_WIDTH each, signed: channel 0 sample.
REQ-006 SHALL have port ch0_valid (input, 1) and port ch0_ready (output, 1): channel 0 handshake.
REQ-007 SHALL have ports ch1_re, ch1_im, ch1_valid and ch1_ready: identical to channel 0, for channel 1.
REQ-008 SHALL have ports pow_re, pow_im, outputs, DIN_WIDTH each, signed: sample issued to the shared complex-power pipeline.
REQ-009 SHALL have port pow_valid, output, 1 bit: issue strobe to the shared pipeline.
REQ-010 SHALL have ports pow_dout, input, 2*DIN_WIDTH+1 bits, unsigned, and pow_dout_valid, input, 1 bit: result returned by the shared pipeline.
REQ-011 SHALL have port dout, output, 2*DIN_WIDTH+1 bits: routed power result.
REQ-012 SHALL have ports dout_valid (output, 1) and dout_ch (output, 1): result strobe and channel that owns the result.
REQ-013 SHALL have port tag_err, output, 1 bit: sticky flag for a result that arrives with no outstanding tag.
REQ-014 SHALL have port occupancy, output, log2(TAG_DEPTH)+1 bits: number of outstanding issued samples.

Function
REQ-015 Transfer: a transfer on channel n SHALL occur in any cycle where chn_valid and chn_ready are both 1.
REQ-016 ch0_ready and ch1_ready SHALL be combinational from the valids, the last-grant pointer and occupancy; at most one SHALL be 1 in any cycle.
REQ-017 Blocking: no ready SHALL assert while occupancy equals TAG_DEPTH, even if a pop occurs in the same cycle.
REQ-018 Single requester: when exactly one channel is valid and there is space, that channel SHALL receive ready.
REQ-019 Round-robin: when both channels are valid, ready SHALL go to the channel not recorded in last_grant.
REQ-020 last_grant SHALL update only on a transfer; a channel that is granted but not valid SHALL not move it.
REQ-021 Issue: on a transfer, pow_re and pow_im SHALL register the granted sample and pow_valid SHALL be 1 on the next cycle.
REQ-022 Issue: in every other cycle pow_valid SHALL be 0, and pow_re/pow_im SHALL hold their last value.
REQ-023 Tag push: on a transfer, the granted channel index SHALL be pushed into the tag FIFO in the same cycle.
REQ-024 Tag pop: on pow_dout_valid with occupancy greater than 0, one tag SHALL be popped.
REQ-025 Result: after a pop, dout SHALL equal pow_dout, dout_ch SHALL equal the popped tag, and dout_valid SHALL be 1, one cycle after pow_dout_valid.
REQ-026 Ordering: results SHALL be routed in issue order.
REQ-027 Push and pop in the same cycle SHALL leave occupancy unchanged, including when occupancy is 1.
REQ-028 FIFO pointers SHALL wrap modulo TAG_DEPTH.
REQ-029 Underflow: on pow_dout_valid with occupancy 0, tag_err SHALL set and stay set until reset, and dout_valid SHALL stay 0 that cycle.
REQ-030 Output backpressure: none; every routed result SHALL be presented for exactly one cycle.
REQ-031 Total latency: from input transfer to dout_valid SHALL be 2 cycles plus the shared pipeline latency.

Reset
REQ-032 While rst is 1, the following SHALL be 0: pow_valid, pow_re, pow_im, dout, dout_valid, dout_ch, tag_err, occupancy and both FIFO pointers.
REQ-033 While rst is 1, last_grant SHALL be 1, so channel 0 wins the first contention.
REQ-034 Reset mid-operation SHALL discard all outstanding tags.
REQ-035 A pow_dout_valid after reset release whose sample was issued before reset SHALL set tag_err.
REQ-036 ch0_ready and ch1_ready SHALL be 0 while rst is 1.

Verification
REQ-037 Contention: both channels valid for 4 cycles (ch0 = 3+4j, ch1 = 1-2j), 2-cycle pipeline model -> grants 0,1,0,1; douts 25,5,25,5 with dout_ch 0,1,0,1.
REQ-038 Single channel: ch1 alone valid for 10 cycles -> ch1_ready is 1 every cycle; 10 results all with dout_ch=1.
REQ-039 Full FIFO: TAG_DEPTH=4, pipeline stalled, both valid -> exactly 4 transfers, then both readies 0 and occupancy=4.
REQ-040 Full FIFO release: one pow_dout_valid on the stalled setup -> no grant in the pop cycle, one grant on the next cycle.
REQ-041 Underflow: pow_dout_valid=1 with pow_dout=7 and occupancy 0 -> dout_valid stays 0 and tag_err=1 until rst.
REQ-042 Reset mid-stream: assert rst with 3 tags outstanding -> occupancy=0 and all outputs 0; the next contention grants ch0 first.
REQ-043 Simultaneous push and pop: at occupancy=1 -> occupancy stays 1 and result order is preserved.
REQ-044 Max magnitude: ch0 = -32768-32768j -> dout = 2147483648, with no overflow.
